// File: rtl/signed_divider_pkg.sv
// Shared widths, iteration count and FSM encoding for the signed restoring divider.
package signed_divider_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/signed_divider_div_step.sv
// One unsigned restoring-division step: shift in the next dividend bit, compare, subtract.
module div_step
    import signed_divider_pkg::*;
#(
    parameter int QW = DIVIDEND_W,
    parameter int RW = DIVISOR_W + 1
) (
    input  logic [RW-1:0] rem_in,
    input  logic [QW-1:0] quo_in,
    input  logic [RW-1:0] dsr,
    output logic [RW-1:0] rem_out,
    output logic [QW-1:0] quo_out
);

    logic [RW:0] shifted;
    logic        ge;

    always_comb begin
        shifted = {rem_in, quo_in[QW-1]};
        ge      = (shifted >= {1'b0, dsr});
        // The partial remainder stays below |divisor|, so dropping the top bit is lossless.
        rem_out = ge ? RW'(shifted - {1'b0, dsr}) : RW'(shifted);
        quo_out = {quo_in[QW-2:0], ge};
    end

endmodule

// File: rtl/signed_divider.sv
// Signed 32/16 divider: magnitude restoring loop over 32 cycles, then one sign fix-up cycle.
module signed_divider
    import signed_divider_pkg::*;
#(
    parameter int DW_DIVIDEND = DIVIDEND_W,
    parameter int DW_DIVISOR  = DIVISOR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DW_DIVIDEND-1:0] dividend,
    input  logic [DW_DIVISOR-1:0]  divisor,
    output logic                   busy,
    output logic                   done,
    output logic [DW_DIVISOR-1:0]  quotient,
    output logic [DW_DIVISOR-1:0]  remainder,
    output logic                   ovf,
    output logic                   dbz
);

    localparam int RW = DW_DIVISOR + 1;

    function automatic logic quo_ovf(input logic [DW_DIVIDEND-1:0] mag, input logic neg);
        logic [DW_DIVIDEND-1:0] lim;
        lim = DW_DIVIDEND'((2 ** (DW_DIVISOR - 1)) - 1);
        return neg ? (mag > lim + DW_DIVIDEND'(1)) : (mag > lim);
    endfunction

    function automatic logic [DW_DIVISOR-1:0] saturate(input logic neg);
        return neg ? {1'b1, {(DW_DIVISOR-1){1'b0}}} : {1'b0, {(DW_DIVISOR-1){1'b1}}};
    endfunction

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DW_DIVIDEND-1:0] dvd_q, dvd_d;
    logic [RW-1:0]          rem_q, rem_d;
    logic [RW-1:0]          dsr_q, dsr_d;
    logic                   sgn_dvd_q, sgn_dvd_d;
    logic                   sgn_dsr_q, sgn_dsr_d;
    logic                   done_q, done_d;
    logic [DW_DIVISOR-1:0]  quotient_q, quotient_d;
    logic [DW_DIVISOR-1:0]  remainder_q, remainder_d;
    logic                   ovf_q, ovf_d;
    logic                   dbz_q, dbz_d;

    logic [RW-1:0]          step_rem;
    logic [DW_DIVIDEND-1:0] step_quo;
    logic                   neg;
    logic [RW-1:0]          dsr_ext;

    div_step #(.QW(DW_DIVIDEND), .RW(RW)) u_step (
        .rem_in  (rem_q),
        .quo_in  (dvd_q),
        .dsr     (dsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        sgn_dvd_d   = sgn_dvd_q;
        sgn_dsr_d   = sgn_dsr_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        neg         = sgn_dvd_q ^ sgn_dsr_q;
        dsr_ext     = {divisor[DW_DIVISOR-1], divisor};

        case (state_q)
            IDLE: begin
                if (start) begin
                    // -2^31 negates to 2^31, which is exact as an unsigned magnitude.
                    sgn_dvd_d = dividend[DW_DIVIDEND-1];
                    sgn_dsr_d = divisor[DW_DIVISOR-1];
                    dvd_d     = sgn_dvd_d ? DW_DIVIDEND'(0) - dividend : dividend;
                    dsr_d     = sgn_dsr_d ? RW'(0) - dsr_ext : dsr_ext;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(ITERATIONS - 1);
                    state_d   = DIV;
                end
            end
            DIV: begin
                dvd_d = step_quo;
                rem_d = step_rem;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (dsr_q == '0) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b1;
                end else if (quo_ovf(dvd_q, neg)) begin
                    quotient_d  = saturate(neg);
                    remainder_d = '0;
                    ovf_d       = 1'b1;
                    dbz_d       = 1'b0;
                end else begin
                    quotient_d  = neg ? DW_DIVISOR'(DW_DIVIDEND'(0) - dvd_q) : DW_DIVISOR'(dvd_q);
                    remainder_d = sgn_dvd_q ? DW_DIVISOR'(RW'(0) - rem_q) : DW_DIVISOR'(rem_q);
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            sgn_dvd_q   <= 1'b0;
            sgn_dsr_q   <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            sgn_dvd_q   <= sgn_dvd_d;
            sgn_dsr_q   <= sgn_dsr_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule
